// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM states, default memory depth and port index type for the data-memory arbiter.
package dmem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef logic port_t;
   localparam int DEPTH_DEFAULT = 256;
   localparam port_t PORT0 = 1'b0;
   localparam port_t PORT1 = 1'b1;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selector; round-robin on ties when DMEM_ARB_RR_EN is defined, else port 0 priority.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic  p0_req,
   input  logic  p1_req,
   input  port_t last_grant,
   output logic  grant_valid,
   output port_t grant_port
);
   assign grant_valid = p0_req | p1_req;
`ifdef DMEM_ARB_RR_EN
   assign grant_port = (p0_req && p1_req) ? ~last_grant : (p0_req ? PORT0 : PORT1);
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign grant_port = p0_req ? PORT0 : PORT1;
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port load/store arbiter and single-cycle access sequencer for the word-addressed data memory.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
)(
   input  logic        clk,
   input  logic        SYS_reset,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_ack,
   output logic [31:0] p0_rdata,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_ack,
   output logic [31:0] p1_rdata,
   output logic        p1_err,
   output logic [31:0] DMEM_address,
   output logic [31:0] DMEM_data_in,
   output logic        DMEM_mem_write,
   output logic        DMEM_mem_read,
   input  logic [31:0] DMEM_data_out
);
   state_t      state, state_n;
   logic        lat_we, err_flag, grant_valid, sel_we, bad;
   logic [31:0] lat_addr, lat_wdata, sel_addr, sel_wdata;
   port_t       gport, last_grant, grant_port;
   logic        take;

   dmem_arb_pick u_pick (
      .p0_req      (p0_req),
      .p1_req      (p1_req),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_port  (grant_port)
   );

   assign sel_we    = grant_port ? p1_we    : p0_we;
   assign sel_addr  = grant_port ? p1_addr  : p0_addr;
   assign sel_wdata = grant_port ? p1_wdata : p0_wdata;
   assign bad       = sel_addr >= 32'(DEPTH);
   assign take      = (state == IDLE) && grant_valid;

`ifdef DMEM_ARB_RR_EN
   always_ff @(posedge clk or posedge SYS_reset) begin
      if (SYS_reset)
         last_grant <= PORT1;
      else if (take)
         last_grant <= grant_port;
   end
`else
   assign last_grant = PORT1;
`endif

   always_ff @(posedge clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         state     <= IDLE;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         gport     <= PORT0;
         err_flag  <= 1'b0;
         p0_rdata  <= '0;
         p1_rdata  <= '0;
      end else begin
         state <= state_n;
         if (take) begin
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            gport     <= grant_port;
            err_flag  <= bad;
         end
         // Out-of-range accesses skip memory and return zero data.
         if (take && bad && grant_port == PORT0)
            p0_rdata <= '0;
         if (take && bad && grant_port == PORT1)
            p1_rdata <= '0;
         if (state == ACCESS && !lat_we && gport == PORT0)
            p0_rdata <= DMEM_data_out;
         if (state == ACCESS && !lat_we && gport == PORT1)
            p1_rdata <= DMEM_data_out;
      end
   end

   always_comb begin
      state_n        = state;
      DMEM_address   = '0;
      DMEM_data_in   = '0;
      DMEM_mem_write = 1'b0;
      DMEM_mem_read  = 1'b0;
      p0_ack         = 1'b0;
      p1_ack         = 1'b0;
      p0_err         = 1'b0;
      p1_err         = 1'b0;
      case (state)
         IDLE:    state_n = grant_valid ? (bad ? RESP : ACCESS) : IDLE;
         ACCESS: begin
            DMEM_address   = lat_addr;
            DMEM_data_in   = lat_wdata;
            DMEM_mem_write = lat_we;
            DMEM_mem_read  = !lat_we;
            state_n        = RESP;
         end
         RESP: begin
            p0_ack  = gport == PORT0;
            p1_ack  = gport == PORT1;
            p0_err  = (gport == PORT0) && err_flag;
            p1_err  = (gport == PORT1) && err_flag;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural 256-word data memory.
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        SYS_reset = 1'b1;
   logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
   logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
   logic        p0_ack, p0_err, p1_ack, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
   logic        DMEM_mem_write, DMEM_mem_read;
   logic [31:0] mem [256];
   int          n_chk = 0, n_fail = 0, n_wr = 0, n_rd = 0, s0;
   logic        quiet_bad;

   dmem_arbiter dut (
      .clk            (clk),
      .SYS_reset      (SYS_reset),
      .p0_req         (p0_req),
      .p0_we          (p0_we),
      .p0_addr        (p0_addr),
      .p0_wdata       (p0_wdata),
      .p0_ack         (p0_ack),
      .p0_rdata       (p0_rdata),
      .p0_err         (p0_err),
      .p1_req         (p1_req),
      .p1_we          (p1_we),
      .p1_addr        (p1_addr),
      .p1_wdata       (p1_wdata),
      .p1_ack         (p1_ack),
      .p1_rdata       (p1_rdata),
      .p1_err         (p1_err),
      .DMEM_address   (DMEM_address),
      .DMEM_data_in   (DMEM_data_in),
      .DMEM_mem_write (DMEM_mem_write),
      .DMEM_mem_read  (DMEM_mem_read),
      .DMEM_data_out  (DMEM_data_out)
   );

   always #5 clk = ~clk;

   assign DMEM_data_out = mem[DMEM_address[7:0]];

   always @(negedge clk) begin
      if (DMEM_mem_write) begin
         mem[DMEM_address[7:0]] <= DMEM_data_in;
         n_wr <= n_wr + 1;
      end
      if (DMEM_mem_read)
         n_rd <= n_rd + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at the negedge before the granting posedge; ends at the ack-cycle negedge with req dropped.
   task automatic serve(input bit port, input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      chk(port ? "p1_acc_addr" : "p0_acc_addr", DMEM_address, addr);
      chk(port ? "p1_acc_read" : "p0_acc_read", DMEM_mem_read, 1);
      chk(port ? "p1_no_early_ack" : "p0_no_early_ack", port ? p1_ack : p0_ack, 0);
      @(negedge clk);
      chk(port ? "p1_ack" : "p0_ack", port ? p1_ack : p0_ack, 1);
      chk(port ? "p0_ack_idle" : "p1_ack_idle", port ? p0_ack : p1_ack, 0);
      chk(port ? "p1_rdata" : "p0_rdata", port ? p1_rdata : p0_rdata, data);
      if (port) p1_req = 1'b0; else p0_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
      repeat (2) @(negedge clk);
      chk("rst_acks", {30'd0, p0_ack, p1_ack}, 0);
      chk("rst_errs", {30'd0, p0_err, p1_err}, 0);
      chk("rst_strobes", {30'd0, DMEM_mem_write, DMEM_mem_read}, 0);
      chk("rst_addr", DMEM_address, 0);
      chk("rst_p0_rdata", p0_rdata, 0);
      chk("rst_p1_rdata", p1_rdata, 0);
      @(posedge clk); #2 SYS_reset = 1'b0;
      quiet_bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         quiet_bad |= p0_ack | p1_ack | p0_err | p1_err | DMEM_mem_write | DMEM_mem_read
                      | (|DMEM_address) | (|DMEM_data_in);
      end
      chk("idle_quiet", quiet_bad, 0);
      // Simultaneous reads: port 0 wins the first tie after reset in both modes.
      p0_we = 1'b0; p0_addr = 32'd1; p0_req = 1'b1;
      p1_we = 1'b0; p1_addr = 32'd2; p1_req = 1'b1;
      serve(0, 32'd1, 32'hA000_0001);
      @(negedge clk);
      p0_addr = 32'd3; p0_req = 1'b1;
`ifdef DMEM_ARB_RR_EN
      serve(1, 32'd2, 32'hA000_0002);
      @(negedge clk);
      serve(0, 32'd3, 32'hA000_0003);
`else
      serve(0, 32'd3, 32'hA000_0003);
      @(negedge clk);
      serve(1, 32'd2, 32'hA000_0002);
`endif
      @(negedge clk);
      p0_we = 1'b1; p0_addr = 32'd5; p0_wdata = 32'hDEAD_BEEF; p0_req = 1'b1;
      s0 = n_wr;
      @(negedge clk);
      chk("wr_strobe", DMEM_mem_write, 1);
      chk("wr_no_read", DMEM_mem_read, 0);
      chk("wr_addr", DMEM_address, 5);
      chk("wr_data", DMEM_data_in, 32'hDEAD_BEEF);
      chk("wr_no_early_ack", p0_ack, 0);
      @(negedge clk);
      chk("wr_ack", p0_ack, 1);
      chk("wr_err", p0_err, 0);
      chk("wr_strobe_off", DMEM_mem_write, 0);
      chk("wr_strobe_cycles", n_wr - s0, 1);
      chk("wr_rdata_kept", p0_rdata, 32'hA000_0003);
      p0_req = 1'b0;
      @(negedge clk);
      p0_we = 1'b0; p0_req = 1'b1;
      serve(0, 32'd5, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("rd_ack_once", p0_ack, 0);
      chk("rd_rdata_held", p0_rdata, 32'hDEAD_BEEF);
      // Out-of-range read on port 1: acked one cycle after the request, no memory strobe.
      p1_we = 1'b0; p1_addr = 32'd300; p1_req = 1'b1;
      s0 = n_wr + n_rd;
      @(negedge clk);
      chk("err_ack", p1_ack, 1);
      chk("err_flag", p1_err, 1);
      chk("err_rdata", p1_rdata, 0);
      chk("err_p0_quiet", {30'd0, p0_ack, p0_err}, 0);
      p1_req = 1'b0;
      @(negedge clk);
      chk("err_ack_off", {30'd0, p1_ack, p1_err}, 0);
      chk("err_no_strobe", n_wr + n_rd - s0, 0);
      p0_addr = 32'd7; p0_req = 1'b1;
      @(posedge clk); #1 p0_addr = 32'd9;
      @(negedge clk);
      chk("latch_addr", DMEM_address, 7);
      @(negedge clk);
      chk("latch_ack", p0_ack, 1);
      chk("latch_rdata", p0_rdata, 32'hA000_0007);
      p0_req = 1'b0;
      @(negedge clk);
      p1_we = 1'b1; p1_addr = 32'd3; p1_wdata = 32'h1234_5678; p1_req = 1'b1;
      @(posedge clk); #2;
      chk("rst_pre_write", DMEM_mem_write, 1);
      SYS_reset = 1'b1;
      #1;
      chk("rst_mid_write", DMEM_mem_write, 0);
      chk("rst_mid_addr", DMEM_address, 0);
      chk("rst_mid_data", DMEM_data_in, 0);
      chk("rst_mid_p0_rdata", p0_rdata, 0);
      chk("rst_mid_ack", p1_ack, 0);
      p1_req = 1'b0;
      @(negedge clk);
      @(posedge clk); #2 SYS_reset = 1'b0;
      chk("rst_mem_unchanged", mem[3], 32'hA000_0003);
      @(negedge clk);
      chk("rst_no_ack", {30'd0, p0_ack, p1_ack}, 0);
      p0_we = 1'b0; p0_addr = 32'd3; p0_req = 1'b1;
      serve(0, 32'd3, 32'hA000_0003);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
